sram_arbiter: RTL

//  Shares the single 256Kx16 board SRAM between three requesters: video refresh, CPU bus, host/JTAG loader.

---
 rtl/sram_arbiter_pkg.sv | 27 ++
 rtl/sram_arb_prio.sv | 66 ++++++
 rtl/sram_arbiter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared types for the SRAM arbiter: FSM states, requester ids and the
// per-requester access descriptor muxed into the SRAM sequencer.
package sram_arbiter_pkg;

   localparam int ADDR_W = 18;
   localparam int DATA_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      RQ_VID  = 2'd0,
      RQ_CPU  = 2'd1,
      RQ_HOST = 2'd2
   } rq_id_t;

   typedef struct packed {
      logic              we;
      logic [1:0]        be;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } sram_req_t;

endpackage

// File: rtl/sram_arb_prio.sv
// Winner select for the SRAM arbiter: fixed priority video > cpu > host,
// with a host starvation counter that forces one host grant after
// STARVE_LIMIT consecutive losses.
// Optional feature macro: SRAM_ARB_HOST_PORT_EN (host port + starvation guard).
module sram_arb_prio
   import sram_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 8
) (
   input  logic   clk50,
   input  logic   reset_n,
   input  logic   vid_req,
   input  logic   cpu_req,
   input  logic   host_req,
   input  logic   idle,
   input  logic   grant,
   output rq_id_t win_id
);

`ifdef SRAM_ARB_HOST_PORT_EN
   logic [7:0] starve_cnt_q, starve_cnt_d;
   logic       host_force;

   assign host_force = host_req && (starve_cnt_q == 8'(STARVE_LIMIT));

   // Winner select; a starved host overrides the fixed order.
   always_comb begin
      win_id = RQ_VID;
      if (host_force)    win_id = RQ_HOST;
      else if (vid_req)  win_id = RQ_VID;
      else if (cpu_req)  win_id = RQ_CPU;
      else if (host_req) win_id = RQ_HOST;
   end

   // Count host losses; clear on a host grant or when host is not asking.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (idle) begin
         if (!host_req) begin
            starve_cnt_d = 8'd0;
         end else if (grant) begin
            if (win_id == RQ_HOST)           starve_cnt_d = 8'd0;
            else if (starve_cnt_q != 8'hFF)  starve_cnt_d = starve_cnt_q + 8'd1;
         end
      end
   end

   // Starvation counter register.
   always_ff @(posedge clk50 or negedge reset_n) begin
      if (!reset_n) starve_cnt_q <= 8'd0;
      else          starve_cnt_q <= starve_cnt_d;
   end
`else
   logic unused_prio;
   assign unused_prio = ^{clk50, reset_n, idle, grant};

   // Plain fixed-priority select; host_req is tied low by the top here.
   always_comb begin
      win_id = RQ_VID;
      if (vid_req)       win_id = RQ_VID;
      else if (cpu_req)  win_id = RQ_CPU;
      else if (host_req) win_id = RQ_HOST;
   end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Shares the board 256Kx16 SRAM between video, CPU and host requesters.
// IDLE -> ACCESS -> DONE sequencer; strobes are registered so the pins are
// glitch-free, read data is captured on the last ACCESS cycle and the
// winner gets a one-cycle ack in DONE.
// Optional feature macro: SRAM_ARB_HOST_PORT_EN. When undefined the host
// port is inert (ack/rdata tied to 0) and no starvation counter exists.
module sram_arbiter
   import sram_arbiter_pkg::*;
#(
   parameter int ACCESS_CYCLES = 2,
   parameter int STARVE_LIMIT  = 8
) (
   input  logic        clk50,
   input  logic        reset_n,
   input  logic        vid_req,
   input  logic [17:0] vid_addr,
   output logic        vid_ack,
   output logic [15:0] vid_rdata,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [1:0]  cpu_be,
   input  logic [17:0] cpu_addr,
   input  logic [15:0] cpu_wdata,
   output logic        cpu_ack,
   output logic [15:0] cpu_rdata,
   input  logic        host_req,
   input  logic        host_we,
   input  logic [1:0]  host_be,
   input  logic [17:0] host_addr,
   input  logic [15:0] host_wdata,
   output logic        host_ack,
   output logic [15:0] host_rdata,
   output logic [17:0] sram_addr,
   output logic [15:0] sram_dq_o,
   output logic        sram_dq_oe,
   input  logic [15:0] sram_dq_i,
   output logic        sram_ce_n,
   output logic        sram_oe_n,
   output logic        sram_we_n,
   output logic        sram_ub_n,
   output logic        sram_lb_n,
   output logic        busy
);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   rq_id_t      id_q, id_d;
   logic        we_q, we_d;
   logic [17:0] addr_q, addr_d;
   logic [15:0] dq_o_q, dq_o_d;
   logic        dq_oe_q, dq_oe_d;
   logic        ce_n_q, ce_n_d;
   logic        oe_n_q, oe_n_d;
   logic        we_n_q, we_n_d;
   logic        ub_n_q, ub_n_d;
   logic        lb_n_q, lb_n_d;
   logic        vid_ack_q, vid_ack_d;
   logic        cpu_ack_q, cpu_ack_d;
   logic [15:0] vid_rdata_q, vid_rdata_d;
   logic [15:0] cpu_rdata_q, cpu_rdata_d;
   logic        host_ack_d;
   logic [15:0] host_rdata_d;

   logic        host_req_eff;
   logic        idle;
   logic        grant;
   rq_id_t      win_id;
   sram_req_t   sel;

`ifdef SRAM_ARB_HOST_PORT_EN
   logic        host_ack_q;
   logic [15:0] host_rdata_q;
   assign host_req_eff = host_req;
   assign host_ack     = host_ack_q;
   assign host_rdata   = host_rdata_q;
`else
   logic unused_host;
   assign unused_host  = ^{host_req, host_we, host_be, host_addr, host_wdata,
                           host_ack_d, host_rdata_d};
   assign host_req_eff = 1'b0;
   assign host_ack     = 1'b0;
   assign host_rdata   = 16'h0000;
`endif

   assign idle  = (state_q == ST_IDLE);
   assign grant = idle && (vid_req || cpu_req || host_req_eff);

   sram_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
      .clk50    (clk50),
      .reset_n  (reset_n),
      .vid_req  (vid_req),
      .cpu_req  (cpu_req),
      .host_req (host_req_eff),
      .idle     (idle),
      .grant    (grant),
      .win_id   (win_id)
   );

   // Mux the winning requester's access descriptor; video is a full-word read.
   always_comb begin
      sel = '0;
      case (win_id)
         RQ_VID: begin
            sel.we   = 1'b0;
            sel.be   = 2'b11;
            sel.addr = vid_addr;
         end
         RQ_CPU: begin
            sel.we    = cpu_we;
            sel.be    = cpu_be;
            sel.addr  = cpu_addr;
            sel.wdata = cpu_wdata;
         end
         RQ_HOST: begin
            sel.we    = host_we;
            sel.be    = host_be;
            sel.addr  = host_addr;
            sel.wdata = host_wdata;
         end
         default: sel = '0;
      endcase
   end

   // Sequencer next state, strobe timing, ack and read-data capture.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      id_d         = id_q;
      we_d         = we_q;
      addr_d       = addr_q;
      dq_o_d       = dq_o_q;
      dq_oe_d      = dq_oe_q;
      ce_n_d       = ce_n_q;
      oe_n_d       = oe_n_q;
      we_n_d       = we_n_q;
      ub_n_d       = ub_n_q;
      lb_n_d       = lb_n_q;
      vid_ack_d    = 1'b0;
      cpu_ack_d    = 1'b0;
      host_ack_d   = 1'b0;
      vid_rdata_d  = vid_rdata_q;
      cpu_rdata_d  = cpu_rdata_q;
`ifdef SRAM_ARB_HOST_PORT_EN
      host_rdata_d = host_rdata_q;
`else
      host_rdata_d = 16'h0000;
`endif
      case (state_q)
         ST_IDLE: begin
            if (grant) begin
               id_d    = win_id;
               we_d    = sel.we;
               addr_d  = sel.addr;
               dq_o_d  = sel.wdata;
               dq_oe_d = sel.we;
               ce_n_d  = 1'b0;
               oe_n_d  = sel.we;
               we_n_d  = !sel.we;
               ub_n_d  = !sel.be[1];
               lb_n_d  = !sel.be[0];
               cnt_d   = 4'(ACCESS_CYCLES - 1);
               state_d = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (cnt_q == 4'd0) begin
               // Strobes release here; addr/dq stay put for write hold time.
               ce_n_d  = 1'b1;
               oe_n_d  = 1'b1;
               we_n_d  = 1'b1;
               ub_n_d  = 1'b1;
               lb_n_d  = 1'b1;
               state_d = ST_DONE;
               case (id_q)
                  RQ_VID:  vid_ack_d  = 1'b1;
                  RQ_CPU:  cpu_ack_d  = 1'b1;
                  RQ_HOST: host_ack_d = 1'b1;
                  default: ;
               endcase
               if (!we_q) begin
                  case (id_q)
                     RQ_VID:  vid_rdata_d  = sram_dq_i;
                     RQ_CPU:  cpu_rdata_d  = sram_dq_i;
                     RQ_HOST: host_rdata_d = sram_dq_i;
                     default: ;
                  endcase
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_DONE: begin
            dq_oe_d = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Sequencer and pin registers; reset forces all strobes inactive at once.
   always_ff @(posedge clk50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         id_q        <= RQ_VID;
         we_q        <= 1'b0;
         addr_q      <= 18'd0;
         dq_o_q      <= 16'd0;
         dq_oe_q     <= 1'b0;
         ce_n_q      <= 1'b1;
         oe_n_q      <= 1'b1;
         we_n_q      <= 1'b1;
         ub_n_q      <= 1'b1;
         lb_n_q      <= 1'b1;
         vid_ack_q   <= 1'b0;
         cpu_ack_q   <= 1'b0;
         vid_rdata_q <= 16'd0;
         cpu_rdata_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         id_q        <= id_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         dq_o_q      <= dq_o_d;
         dq_oe_q     <= dq_oe_d;
         ce_n_q      <= ce_n_d;
         oe_n_q      <= oe_n_d;
         we_n_q      <= we_n_d;
         ub_n_q      <= ub_n_d;
         lb_n_q      <= lb_n_d;
         vid_ack_q   <= vid_ack_d;
         cpu_ack_q   <= cpu_ack_d;
         vid_rdata_q <= vid_rdata_d;
         cpu_rdata_q <= cpu_rdata_d;
      end
   end

`ifdef SRAM_ARB_HOST_PORT_EN
   // Host ack/rdata registers exist only with the host port enabled.
   always_ff @(posedge clk50 or negedge reset_n) begin
      if (!reset_n) begin
         host_ack_q   <= 1'b0;
         host_rdata_q <= 16'd0;
      end else begin
         host_ack_q   <= host_ack_d;
         host_rdata_q <= host_rdata_d;
      end
   end
`endif

   assign sram_addr  = addr_q;
   assign sram_dq_o  = dq_o_q;
   assign sram_dq_oe = dq_oe_q;
   assign sram_ce_n  = ce_n_q;
   assign sram_oe_n  = oe_n_q;
   assign sram_we_n  = we_n_q;
   assign sram_ub_n  = ub_n_q;
   assign sram_lb_n  = lb_n_q;
   assign vid_ack    = vid_ack_q;
   assign cpu_ack    = cpu_ack_q;
   assign vid_rdata  = vid_rdata_q;
   assign cpu_rdata  = cpu_rdata_q;
   assign busy       = !idle;

endmodule
